// File: rtl/biquad_sched.sv
// Biquad section controller: one shared signed multiplier stepped over five taps, with
// valid/ready handshakes and a double-buffered coefficient bank. BIQUAD_SAT_FLAG_EN adds sat_sticky/sat_clr.
module biquad_sched #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = 32,
  parameter int unsigned FRAC = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  input  logic          cfg_commit,
`ifdef BIQUAD_SAT_FLAG_EN
  input  logic          sat_clr,
  output logic          sat_sticky,
`endif
  output logic          busy
);

  localparam int unsigned NT = 5;
  localparam int unsigned PW = DW + CW;
  localparam int unsigned TW = PW - FRAC;
  localparam int unsigned AW = DW + CW - FRAC + 3;

  localparam logic [CW-1:0]         UNITY    = CW'(1) << FRAC;
  localparam logic [NT-1:0][CW-1:0] BANK_RST = {{((NT-1)*CW){1'b0}}, UNITY};
  localparam logic signed [AW-1:0]  SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0]  SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              tap_q, tap_d;
  logic signed [DW-1:0]    x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [DW-1:0]    y1_q, y1_d, y2_q, y2_d;
  logic signed [TW-1:0]    term_q, term_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    pend_q, pend_d;
  logic [NT-1:0][CW-1:0]   act_q, act_d, shd_q, shd_d;

  logic signed [DW-1:0]    op_c;
  logic signed [CW-1:0]    coef_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [TW-1:0]    term_c;
  logic                    sat_hi_c, sat_lo_c;
  logic signed [DW-1:0]    sat_c;

  // Shared multiplier: operand/coefficient pair picked by tap, floored by FRAC.
  always_comb begin
    op_c   = '0;
    coef_c = '0;
    case (tap_q)
      3'd0:    begin op_c = x0_q; coef_c = act_q[0]; end
      3'd1:    begin op_c = x1_q; coef_c = act_q[1]; end
      3'd2:    begin op_c = x2_q; coef_c = act_q[2]; end
      3'd3:    begin op_c = y1_q; coef_c = act_q[3]; end
      3'd4:    begin op_c = y2_q; coef_c = act_q[4]; end
      default: begin op_c = '0;   coef_c = '0;       end
    endcase
    prod_c = PW'(op_c) * PW'(coef_c);
    term_c = TW'(prod_c >>> FRAC);
  end

  always_comb begin
    sat_hi_c = acc_q > SAT_MAX;
    sat_lo_c = acc_q < SAT_MIN;
    if (sat_hi_c)      sat_c = {1'b0, {(DW-1){1'b1}}};
    else if (sat_lo_c) sat_c = {1'b1, {(DW-1){1'b0}}};
    else               sat_c = acc_q[DW-1:0];
  end

  assign in_ready  = (state_q == S_IDLE) && !out_valid_q && !pend_q;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next state; the term register adds one drain step (tap 5) before DONE.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    term_d      = term_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    pend_d      = pend_q | cfg_commit;
    act_d       = act_q;
    shd_d       = shd_q;

    for (int unsigned i = 0; i < NT; i++) begin
      if (cfg_we && (cfg_addr == 3'(i))) shd_d[i] = cfg_data;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          act_d  = shd_d;
          pend_d = cfg_commit;
        end else if (in_valid && in_ready) begin
          x0_d    = in_data;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (tap_q != 3'd0) acc_d = acc_q + AW'(term_q);
        if (tap_q == 3'(NT)) begin
          state_d = S_DONE;
        end else begin
          term_d = term_c;
          tap_d  = tap_q + 3'd1;
        end
      end
      S_DONE: begin
        out_data_d  = sat_c;
        out_valid_d = 1'b1;
        x2_d        = x1_q;
        x1_d        = x0_q;
        y2_d        = y1_q;
        y1_d        = sat_c;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      term_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pend_q      <= 1'b0;
      act_q       <= BANK_RST;
      shd_q       <= BANK_RST;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      term_q      <= term_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
    end
  end

`ifdef BIQUAD_SAT_FLAG_EN
  logic sticky_q, sticky_d;

  // A clip in DONE overrides a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (sat_clr) sticky_d = 1'b0;
    if ((state_q == S_DONE) && (sat_hi_c || sat_lo_c)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign sat_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_biquad_sched.sv
// Directed bench for biquad_sched: expected outputs come from a behavioural difference-equation
// model and are queued at accept time, then compared when the DUT presents each output.
module tb_biquad_sched;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          cfg_we, cfg_commit, busy;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
`ifdef BIQUAD_SAT_FLAG_EN
  logic          sat_clr, sat_sticky;
  bit            m_sticky;
`endif

  always #5 clk = ~clk;

  biquad_sched dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
`ifdef BIQUAD_SAT_FLAG_EN
    .sat_clr(sat_clr), .sat_sticky(sat_sticky),
`endif
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] exp_q[$];
  longint m_act[5];
  longint m_sh[5];
  longint m_x1, m_x2, m_y1, m_y2;
  bit     m_pend;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_act[i] = 0;
      m_sh[i]  = 0;
    end
    m_act[0] = 64'sd1 <<< 30;
    m_sh[0]  = 64'sd1 <<< 30;
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    m_pend = 1'b0;
`ifdef BIQUAD_SAT_FLAG_EN
    m_sticky = 1'b0;
`endif
    exp_q.delete();
  endtask

  task automatic model_push(input logic signed [15:0] x);
    longint xl, acc, y;
    xl = x;
    if (m_pend) begin
      m_act  = m_sh;
      m_pend = 1'b0;
    end
    acc = ((xl * m_act[0]) >>> 30) + ((m_x1 * m_act[1]) >>> 30) + ((m_x2 * m_act[2]) >>> 30)
        + ((m_y1 * m_act[3]) >>> 30) + ((m_y2 * m_act[4]) >>> 30);
    y = acc;
    if (acc > 32767) y = 32767;
    else if (acc < -32768) y = -32768;
`ifdef BIQUAD_SAT_FLAG_EN
    if (y != acc) m_sticky = 1'b1;
`endif
    m_x2 = m_x1; m_x1 = xl; m_y2 = m_y1; m_y1 = y;
    exp_q.push_back(16'(y));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic signed [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < 3'd5) m_sh[addr] = data;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic accept(input logic signed [15:0] x);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 64'(w < 40), 1);
    in_data = x; in_valid = 1'b1;
    model_push(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_out(input int k0, input bit chk_lat);
    int k = k0;
    logic signed [15:0] e;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_seen", out_valid, 1);
    if (chk_lat) check("latency", k, 7);
    check("ready_low_while_valid", in_ready, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("out_data", $signed(out_data), e);
    end
`ifdef BIQUAD_SAT_FLAG_EN
    check("sat_sticky", sat_sticky, m_sticky);
`endif
    @(negedge clk);
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    logic signed [15:0] held;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
`ifdef BIQUAD_SAT_FLAG_EN
    sat_clr = 1'b0;
`endif
    apply_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Unity passthrough: latency and 9-cycle turnaround.
    accept(16'sd1000);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", in_ready, 0);
    get_out(0, 1'b1);
    check("ready_again", in_ready, 1);

    // b0 = 0.5 with floor rounding.
    cfg_write(3'd0, 32'sh2000_0000);
    commit();
    accept(-16'sd3);
    get_out(0, 1'b1);
    accept(16'sd7);
    get_out(0, 1'b1);

    // First-order recursion y = x + 0.5*y1.
    apply_reset();
    cfg_write(3'd3, 32'sh2000_0000);
    commit();
    accept(16'sd1000); get_out(0, 1'b1);
    accept(16'sd0);    get_out(0, 1'b1);
    accept(16'sd0);    get_out(0, 1'b1);
    accept(16'sd0);    get_out(0, 1'b1);
    check("decay_last_y1", m_y1, 125);

    // Saturation at both rails.
    apply_reset();
    cfg_write(3'd0, 32'sh7FFF_FFFF);
    commit();
    accept(16'sd30000);  get_out(0, 1'b1);
    accept(-16'sd30000); get_out(0, 1'b1);
`ifdef BIQUAD_SAT_FLAG_EN
    repeat (3) @(negedge clk);
    check("sticky_holds", sat_sticky, 1);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    m_sticky = 1'b0;
    check("sticky_cleared", sat_sticky, 0);
`endif

    // Commit during MAC of sample A only affects sample B.
    apply_reset();
    accept(16'sd800);
    cfg_write(3'd0, 32'sh2000_0000);
    commit();
    get_out(2, 1'b1);
    check("pend_blocks_ready", in_ready, 0);
    check("pend_idle_busy", busy, 0);
    @(negedge clk);
    check("ready_after_copy", in_ready, 1);
    accept(16'sd800);
    get_out(0, 1'b1);

    // Backpressure: output held, no new sample taken.
    out_ready = 1'b0;
    accept(16'sd1234);
    held = exp_q[0];
    repeat (7) @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd999;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", $signed(out_data), held);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", out_valid, 0);

    // Reset mid-MAC, then confirm history and banks were cleared.
    accept(16'sd5000);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    accept(16'sd1000);
    get_out(0, 1'b1);
    cfg_write(3'd1, 32'sh4000_0000);
    commit();
    accept(16'sd0);
    get_out(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
